// File: rtl/pipo_load_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_load_arbiter_pkg
//  Purpose  : State encoding and default sizing shared by the load arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package pipo_load_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int c_N_REQ_DEFAULT       = 4;
    localparam int c_WIDTH_DEFAULT       = 4;
    localparam int c_HOLD_CYCLES_DEFAULT = 2;

    // Hold counter width; a single-cycle hold still needs one bit.
    function automatic int cnt_width(input int hold_cycles);
        return (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipo_load_arbiter_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_reg
//  Purpose  : Shared parallel-in/parallel-out register with load enable.
//  Revision : 1.0 - initial release
// ============================================================================
module pipo_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
        end else if (enable) begin
            r_data <= pin;
        end
    end

    assign pout = r_data;

endmodule
`default_nettype wire

// File: rtl/pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipo_load_arbiter
//  Purpose  : Round-robin arbiter granting one requester at a time a load
//             into a shared PIPO register, followed by a fixed hold time.
//  Revision : 1.0 - initial release
// ============================================================================
module pipo_load_arbiter
    import pipo_load_arbiter_pkg::*;
#(
    parameter int N_REQ       = c_N_REQ_DEFAULT,
    parameter int WIDTH       = c_WIDTH_DEFAULT,
    parameter int HOLD_CYCLES = c_HOLD_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   data,
    output logic [N_REQ-1:0]         grant,
    output logic [WIDTH-1:0]         pout,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     valid,
    output logic                     busy
);

    localparam int c_OWNER_W = $clog2(N_REQ);
    localparam int c_CNT_W   = cnt_width(HOLD_CYCLES);

    localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_OWNER_W-1:0] c_IDX_LAST = c_OWNER_W'(N_REQ - 1);
    localparam logic [c_OWNER_W:0]   c_IDX_MOD  = (c_OWNER_W + 1)'(N_REQ);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_OWNER_W-1:0]   r_ptr;
    logic [c_OWNER_W-1:0]   r_winner;
    logic [c_OWNER_W-1:0]   r_owner;
    logic [c_OWNER_W-1:0]   w_sel;
    logic [c_OWNER_W-1:0]   w_ptr_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_valid;
    logic                   w_any;
    logic                   w_load_en;
    logic [N_REQ-1:0]       w_grant;
    logic [WIDTH-1:0]       w_pin;

    assign w_any = |req;

    // Round-robin search: first set request at or after r_ptr, wrapping.
    always_comb begin
        logic                 found;
        logic [c_OWNER_W:0]   sum;
        logic [c_OWNER_W-1:0] idx;
        w_sel = r_ptr;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, r_ptr} + (c_OWNER_W + 1)'(k);
            if (sum >= c_IDX_MOD) begin
                sum = sum - c_IDX_MOD;
            end
            idx = sum[c_OWNER_W-1:0];
            if (!found && req[idx]) begin
                w_sel = idx;
                found = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (r_winner == c_IDX_LAST) ? '0 : r_winner + 1'b1;
    assign w_pin     = data[r_winner*WIDTH +: WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = 1'b0;
        w_grant     = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_load_en   = 1'b1;
                w_grant     = {{(N_REQ-1){1'b0}}, 1'b1} << r_winner;
                w_state_nxt = HOLD;
            end
            HOLD: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_winner <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_winner <= w_sel;
                    end
                end
                LOAD: begin
                    r_owner <= r_winner;
                    r_valid <= 1'b1;
                    r_ptr   <= w_ptr_nxt;
                    r_cnt   <= '0;
                end
                HOLD: begin
                    // Counter parks at zero once the hold window closes.
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    pipo_reg #(
        .WIDTH (WIDTH)
    ) u_pipo_reg (
        .clk    (clk),
        .rst    (rst),
        .enable (w_load_en),
        .pin    (w_pin),
        .pout   (pout)
    );

    assign grant = w_grant;
    assign owner = r_owner;
    assign valid = r_valid;
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pipo_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipo_load_arbiter
//  Purpose  : Self-checking bench for pipo_load_arbiter against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipo_load_arbiter;

    localparam int N = 4;
    localparam int W = 4;
    localparam int H = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   data;
    logic [N-1:0]     grant;
    logic [W-1:0]     pout;
    logic [1:0]       owner;
    logic             valid;
    logic             busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: m_left counts remaining busy cycles (LOAD + H hold cycles).
    int           m_left;
    int           m_ptr;
    int           m_win;
    int           m_owner;
    logic [W-1:0] m_pout;
    logic         m_valid;

    pipo_load_arbiter #(
        .N_REQ       (N),
        .WIDTH       (W),
        .HOLD_CYCLES (H)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .grant (grant),
        .pout  (pout),
        .owner (owner),
        .valid (valid),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] exp_grant();
        if (m_left == 1 + H) return N'(1) << m_win;
        return '0;
    endfunction

    task automatic model_reset();
        m_left  = 0;
        m_ptr   = 0;
        m_win   = 0;
        m_owner = 0;
        m_pout  = '0;
        m_valid = 1'b0;
    endtask

    task automatic step();
        logic [N-1:0]   sreq;
        logic [N*W-1:0] sdata;
        sreq  = req;
        sdata = data;
        @(posedge clk);
        cyc++;
        if (m_left == 0) begin
            if (sreq != '0) begin
                m_win  = rr_pick(m_ptr, sreq);
                m_left = 1 + H;
            end
        end else if (m_left == 1 + H) begin
            m_pout  = sdata[m_win*W +: W];
            m_owner = m_win;
            m_valid = 1'b1;
            m_ptr   = (m_win + 1) % N;
            m_left  = H;
        end else begin
            m_left--;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst  = 1'b0;
        req  = '0;
        data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        req  = '0;
        data = '0;
        model_reset();
        #1;
        checks++;
        if (grant !== '0 || pout !== '0 || owner !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got grant=%b pout=%h owner=%0d valid=%b busy=%b exp all zero",
                     grant, pout, owner, valid, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b grant=%b exp busy=0 grant=0", busy, grant);
        end
        req = 4'b1000;
        step();
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL first_decision got grant=%b exp 1000", grant);
        end
    endtask

    task automatic test_reset_mid();
        // Mid-HOLD abort.
        apply_reset();
        req  = 4'b0010;
        data = 16'h0A00 | 16'h0070;
        step();
        req = '0;
        step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (pout !== '0 || valid !== 1'b0 || busy !== 1'b0 || grant !== '0 || owner !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold got pout=%h valid=%b busy=%b grant=%b owner=%0d exp all zero",
                     pout, valid, busy, grant, owner);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Mid-LOAD abort: nothing of the transfer may land.
        req  = 4'b0001;
        data = 16'h0009;
        step();
        req = '0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (grant !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_load got grant=%b busy=%b exp 0 0", grant, busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) step();
        checks++;
        if (pout !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_partial got pout=%h valid=%b exp 0 0", pout, valid);
        end
    endtask

    task automatic test_single();
        int busy_cnt;
        int n;
        apply_reset();
        req  = 4'b0100;
        data = (N*W)'($urandom);
        data[11:8] = 4'hA;
        step();
        req = '0;
        busy_cnt = busy ? 1 : 0;
        checks++;
        if (grant !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b exp 0100", grant);
        end
        step();
        if (busy) busy_cnt++;
        checks++;
        if (grant !== '0 || pout !== 4'hA || owner !== 2'd2 || valid !== 1'b1) begin
            errors++;
            $display("FAIL single_load got grant=%b pout=%h owner=%0d valid=%b exp 0000 a 2 1",
                     grant, pout, owner, valid);
        end
        n = 0;
        while (busy && n < 10) begin
            step();
            n++;
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 1 + H) begin
            errors++;
            $display("FAIL single_busy_len got %0d exp %0d", busy_cnt, 1 + H);
        end
    endtask

    task automatic test_fairness();
        int last_cyc;
        apply_reset();
        req = 4'b1111;
        last_cyc = 0;
        for (int i = 0; i < 12; i++) begin
            int waited;
            waited = 0;
            data = (N*W)'($urandom);
            step();
            while (grant === '0 && waited < 8) begin
                step();
                waited++;
            end
            checks++;
            if (grant !== (N'(1) << (i % N))) begin
                errors++;
                $display("FAIL fair_grant load=%0d got %b exp %b", i, grant, N'(1) << (i % N));
            end
            if (i > 0) begin
                checks++;
                if (cyc - last_cyc !== 2 + H) begin
                    errors++;
                    $display("FAIL fair_spacing load=%0d got %0d exp %0d", i, cyc - last_cyc, 2 + H);
                end
            end
            last_cyc = cyc;
            step();
            checks++;
            if (owner !== 2'(i % N) || pout !== m_pout) begin
                errors++;
                $display("FAIL fair_owner load=%0d got owner=%0d pout=%h exp %0d %h",
                         i, owner, pout, i % N, m_pout);
            end
        end
        req = '0;
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 4'b0100;
        step();
        req = '0;
        repeat (1 + H) step();
        req  = 4'b0001;
        data = 16'h0003;
        step();
        req = '0;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_grant got %b exp 0001", grant);
        end
        step();
        checks++;
        if (owner !== 2'd0 || pout !== 4'h3) begin
            errors++;
            $display("FAIL wrap_owner got owner=%0d pout=%h exp 0 3", owner, pout);
        end
        repeat (H) step();
        req = 4'b0011;
        step();
        req = '0;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ptr got %b exp 0010", grant);
        end
        repeat (1 + H) step();
    endtask

    task automatic test_ignore_busy();
        int  n;
        bit  seen;
        logic prev_busy;
        apply_reset();
        req  = 4'b0001;
        data = (N*W)'($urandom);
        step();
        req = '0;
        step();
        req       = 4'b0010;
        n         = 0;
        seen      = 1'b0;
        prev_busy = busy;
        while (n < 10 && !seen) begin
            step();
            n++;
            if (grant !== '0) begin
                seen = 1'b1;
                checks++;
                if (grant !== 4'b0010 || prev_busy !== 1'b0 || n !== 3) begin
                    errors++;
                    $display("FAIL busy_ignore got grant=%b prev_busy=%b after=%0d exp 0010 0 3",
                             grant, prev_busy, n);
                end
            end
            prev_busy = busy;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL busy_ignore_timeout got no grant exp grant=0010");
        end
        req = '0;
        repeat (1 + H) step();
    endtask

    task automatic test_data_isolation();
        apply_reset();
        req  = 4'b0001;
        data = 16'h0005;
        step();
        req = '0;
        step();
        data[3:0] = 4'hF;
        repeat (3) step();
        checks++;
        if (pout !== 4'h5 || owner !== 2'd0) begin
            errors++;
            $display("FAIL data_isolation got pout=%h owner=%0d exp 5 0", pout, owner);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] eg;
            req  = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            data = (N*W)'($urandom);
            step();
            eg = exp_grant();
            checks++;
            if (grant !== eg || busy !== (m_left > 0)) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d got grant=%b busy=%b exp %b %b",
                         cyc, grant, busy, eg, m_left > 0);
            end
            checks++;
            if (pout !== m_pout || owner !== 2'(m_owner) || valid !== m_valid) begin
                errors++;
                $display("FAIL rand_data cyc=%0d got pout=%h owner=%0d valid=%b exp %h %0d %b",
                         cyc, pout, owner, valid, m_pout, m_owner, m_valid);
            end
        end
        req = '0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_reset_mid();
        test_single();
        test_fairness();
        test_wrap();
        test_ignore_busy();
        test_data_isolation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
